// File: rtl/alu_pkg.sv
// Shared ALU encodings, flag positions, arbiter state type and the captured request bundle.
// Imported by the arbiter, its ALU and the requester interface.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester's request and response valid/ready channels.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: add/sub/and/or with {N,Z,C,V} flags.
// For sub, C is the inverted borrow (set when a >= b unsigned); and/or report C=V=0.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic        carry;
    logic        ovf;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                result = sum[31:0];
                carry  = sum[32];
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB: begin
                result = diff[31:0];
                carry  = diff[32];
                ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_AND:  result = a & b;
            default: result = a | b;
        endcase
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = (result == 32'd0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters; accept at T, response valid at T+2.
// Optional ALU_ARB_STATS_EN adds saturating per-requester grant counters with a sync clear.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit INIT_PRIO = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_arbiter_if.slave  ch0,
    alu_arbiter_if.slave  ch1,
    output logic          busy
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        prio;
    logic        owner;
    logic        gnt_sel;
    logic        take;
    logic        rsp_done;
    alu_req_t    req_q;
    alu_req_t    req_sel;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [31:0] res0_q;
    logic [31:0] res1_q;
    logic [3:0]  flg0_q;
    logic [3:0]  flg1_q;

    // A lone valid wins outright; a tie goes to prio.
    always_comb begin
        gnt_sel  = (ch0.req_valid && ch1.req_valid) ? prio : ch1.req_valid;
        take     = (state == IDLE) && (ch0.req_valid || ch1.req_valid);
        req_sel  = gnt_sel ? alu_req_t'{ch1.req_a, ch1.req_b, ch1.req_op}
                           : alu_req_t'{ch0.req_a, ch0.req_b, ch0.req_op};
        rsp_done = (state == RESP) && (owner ? ch1.rsp_ready : ch0.rsp_ready);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= '0;
            owner  <= 1'b0;
            prio   <= INIT_PRIO;
            res0_q <= '0;
            res1_q <= '0;
            flg0_q <= '0;
            flg1_q <= '0;
        end else begin
            if (take) begin
                req_q <= req_sel;
                owner <= gnt_sel;
            end
            if (state == EXEC) begin
                if (owner) begin
                    res1_q <= alu_result;
                    flg1_q <= alu_flags;
                end else begin
                    res0_q <= alu_result;
                    flg0_q <= alu_flags;
                end
            end
            if (rsp_done) begin
                prio <= ~owner;
            end
        end
    end

    alu_arbiter_alu u_alu (
        .a      (req_q.a),
        .b      (req_q.b),
        .op     (req_q.op),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Ready depends only on state and valid, never on rsp_ready.
    assign ch0.req_ready  = take && !gnt_sel;
    assign ch1.req_ready  = take && gnt_sel;
    assign ch0.rsp_valid  = (state == RESP) && !owner;
    assign ch1.rsp_valid  = (state == RESP) && owner;
    assign ch0.rsp_result = res0_q;
    assign ch1.rsp_result = res1_q;
    assign ch0.rsp_flags  = flg0_q;
    assign ch1.rsp_flags  = flg1_q;
    assign busy           = (state != IDLE);

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (stats_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (ch0.req_valid && ch0.req_ready && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (ch1.req_valid && ch1.req_ready && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, flags, round-robin, stall, mid-op reset,
// and grant counters when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

    logic clk;
    logic reset_n;
    logic busy;
    int   n_cmp;
    int   n_err;
    int   cyc;

    alu_arbiter_if ch0_if ();
    alu_arbiter_if ch1_if ();

`ifdef ALU_ARB_STATS_EN
    logic       stats_clr;
    logic [1:0] grant_cnt0;
    logic [1:0] grant_cnt1;
`endif

    alu_arbiter #(.INIT_PRIO(1'b0), .CNT_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ch0     (ch0_if),
        .ch1     (ch1_if),
        .busy    (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit r, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
        if (r) begin
            ch1_if.req_valid = v; ch1_if.req_a = a; ch1_if.req_b = b; ch1_if.req_op = op;
        end else begin
            ch0_if.req_valid = v; ch0_if.req_a = a; ch0_if.req_b = b; ch0_if.req_op = op;
        end
    endtask

    function automatic logic rdy(input bit r);
        return r ? ch1_if.req_ready : ch0_if.req_ready;
    endfunction

    function automatic logic rvld(input bit r);
        return r ? ch1_if.rsp_valid : ch0_if.rsp_valid;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 2'b00);
        drive(1'b1, 1'b0, '0, '0, 2'b00);
        ch0_if.rsp_ready = 1'b1;
        ch1_if.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issue one op on requester r (called just after a rising edge) and return its response.
    task automatic do_op(input string tag, input bit r, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_res, input logic [3:0] exp_flg);
        int n;
        drive(r, 1'b1, a, b, op);
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy(r) && n < 20);
        if (!rdy(r)) chk({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk); #1;
        drive(r, 1'b0, a, b, op);
        n = 0;
        do begin @(negedge clk); n++; end while (!rvld(r) && n < 20);
        if (!rvld(r)) chk({tag, "_rsp_timeout"}, 0, 1);
        chk({tag, "_res"}, r ? ch1_if.rsp_result : ch0_if.rsp_result, exp_res);
        chk({tag, "_flg"}, r ? ch1_if.rsp_flags : ch0_if.rsp_flags, exp_flg);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        int   last;
        int   n;
        bit   g;
        bit   seen;
        logic [31:0] ta0, ta1, exp;

        n_cmp = 0; n_err = 0; cyc = 0;
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", {ch0_if.req_ready, ch1_if.req_ready}, 0);
        chk("rst_rvld", {ch0_if.rsp_valid, ch1_if.rsp_valid}, 0);
        chk("rst_res", {ch0_if.rsp_result, ch1_if.rsp_result}, 0);
        chk("rst_flg", {ch0_if.rsp_flags, ch1_if.rsp_flags}, 0);
        @(posedge clk); #1;

        // req0 alone, cycle-exact latency
        drive(1'b0, 1'b1, 32'd5, 32'd3, 2'b00);
        @(negedge clk);
        chk("t1_rdy_T", {ch0_if.req_ready, ch1_if.req_ready}, 2'b10);
        t0 = cyc;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd5, 32'd3, 2'b00);
        @(negedge clk);
        chk("t1_vld_T1", {ch0_if.rsp_valid, busy}, 2'b01);
        @(negedge clk);
        chk("t1_lat", cyc - t0, 2);
        chk("t1_vld_T2", {ch0_if.rsp_valid, ch1_if.rsp_valid}, 2'b10);
        chk("t1_res", ch0_if.rsp_result, 32'd8);
        chk("t1_flg", ch0_if.rsp_flags, 4'b0000);
        @(negedge clk);
        chk("t1_idle", {busy, ch0_if.rsp_valid}, 0);
        @(posedge clk); #1;

        // flags on requester 1 and boundary arithmetic on requester 0
        do_op("sub_neg", 1'b1, 32'd3, 32'd5, 2'b01, 32'hFFFF_FFFE, 4'b1000);
        do_op("sub_zero", 1'b1, 32'd5, 32'd5, 2'b01, 32'h0, 4'b0110);
        do_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 4'b1001);
        do_op("add_carry", 1'b0, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'h0, 4'b0110);
        do_op("or_op", 1'b1, 32'h8000_0000, 32'h1, 2'b11, 32'h8000_0001, 4'b1000);

        // both valid continuously: strict alternation from INIT_PRIO=0
        do_reset();
        ta0 = 32'd10; ta1 = 32'd100;
        drive(1'b0, 1'b1, ta0, 32'd1, 2'b00);
        drive(1'b1, 1'b1, ta1, 32'd1, 2'b01);
        last = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end
                while (!(ch0_if.req_ready || ch1_if.req_ready) && n < 20);
            if (!(ch0_if.req_ready || ch1_if.req_ready)) chk("alt_timeout", 0, 1);
            g = ch1_if.req_ready;
            chk("alt_gnt", g, k % 2);
            if (k > 0) chk("alt_gap", cyc - last, 3);
            last = cyc;
            exp = g ? ta1 - 32'd1 : ta0 + 32'd1;
            @(posedge clk); #1;
            if (g) begin ta1 = ta1 + 32'd7; ch1_if.req_a = ta1; end
            else   begin ta0 = ta0 + 32'd3; ch0_if.req_a = ta0; end
            @(negedge clk); @(negedge clk);
            chk("alt_vld", {ch0_if.rsp_valid, ch1_if.rsp_valid}, g ? 2'b01 : 2'b10);
            chk("alt_res", g ? ch1_if.rsp_result : ch0_if.rsp_result, exp);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 2'b00);
        drive(1'b1, 1'b0, '0, '0, 2'b00);
        @(negedge clk);
        chk("alt_drain", busy, 0);
        @(posedge clk); #1;

        // RESP stalled by rsp0_ready low; req1 waits and then wins next
        ch0_if.rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 32'd7, 32'd2, 2'b01);
        drive(1'b1, 1'b1, 32'h0F0, 32'h00F, 2'b11);
        @(negedge clk);
        chk("stall_gnt", {ch0_if.req_ready, ch1_if.req_ready}, 2'b10);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 2'b00);
        @(negedge clk); @(negedge clk);
        chk("stall_vld", ch0_if.rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_hold", {ch1_if.req_ready, ch0_if.rsp_valid, ch1_if.rsp_valid,
                               ch0_if.rsp_result, ch0_if.rsp_flags}, {3'b010, 32'd5, 4'b0010});
        end
        @(posedge clk); #1;
        ch0_if.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_xfer_rdy", ch1_if.req_ready, 0);
        @(negedge clk);
        chk("stall_next_gnt", {ch0_if.rsp_valid, ch1_if.req_ready}, 2'b01);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, '0, '0, 2'b00);
        @(negedge clk); @(negedge clk);
        chk("stall_r1", {ch1_if.rsp_valid, ch1_if.rsp_result, ch1_if.rsp_flags},
            {1'b1, 32'h0FF, 4'b0000});
        @(posedge clk); #1;

        // reset_n pulsed during EXEC aborts the transaction
        drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00);
        @(negedge clk);
        chk("abort_acc", ch0_if.req_ready, 1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 2'b00);
        @(negedge clk);
        chk("abort_exec", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_out", {busy, ch0_if.rsp_valid, ch1_if.rsp_valid, ch0_if.req_ready,
                          ch1_if.req_ready, ch0_if.rsp_result, ch1_if.rsp_result,
                          ch0_if.rsp_flags, ch1_if.rsp_flags}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = seen | ch0_if.rsp_valid | ch1_if.rsp_valid | busy;
        end
        chk("abort_no_rsp", seen, 0);
        @(posedge clk); #1;
        do_op("post_abort_and", 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 2'b10, 32'h0000_F000, 4'b0000);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_op("cnt_op", 1'b0, k, 32'd1, 2'b00, k + 1, 4'b0000);
        end
        chk("cnt_sat", {grant_cnt0, grant_cnt1}, {2'd3, 2'd0});
        drive(1'b0, 1'b1, 32'd1, 32'd1, 2'b00);
        stats_clr = 1'b1;
        @(negedge clk);
        chk("clr_gnt", ch0_if.req_ready, 1);
        @(posedge clk); #1;
        stats_clr = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 2'b00);
        chk("cnt_clr", {grant_cnt0, grant_cnt1}, 0);
        repeat (3) @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
